issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Instruction buffer between the decode stage and the backend instruction issuer; decoupling FIFO for decoded-instruction packets.
- Decoder pushes 123-bit packets; the backend pops them through the issue_q_ren / issue_q_rok / issue_q_rdata handshake.
- First-word-fall-through: the head packet is presented with issue_q_rok=1 before it is popped.
- Synchronous flush discards all buffered packets on branch mispredict, driven by the backend bpu_flush.

Parameters:
- ISSUE_Q_WIDTH, 123, packet width in bits.
- ISSUE_Q_DEPTH, 8, number of entries; power of two, at least 2.
- AFULL_LEVEL, 6, occupancy at or above which issue_q_afull asserts; range 1..ISSUE_Q_DEPTH.
- DEPTH_LOG2, $clog2(ISSUE_Q_DEPTH), derived pointer width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTN  input  1  asynchronous active-low reset.
- issue_q_wen  input  1  decoder push request.
- issue_q_wdata  input  ISSUE_Q_WIDTH  packet to push.
- issue_q_wok  output  1  space available; a push is accepted only when wen=1 and wok=1.
- issue_q_afull  output  1  count >= AFULL_LEVEL; lets the decoder stall early.
- issue_q_ren  input  1  backend pop request.
- issue_q_rok  output  1  head packet valid (queue not empty).
- issue_q_rdata  output  ISSUE_Q_WIDTH  head packet.
- issue_q_count  output  DEPTH_LOG2+1  current occupancy, 0..ISSUE_Q_DEPTH.
- flush  input  1  synchronous discard of all entries.

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-low, RSTN.
- Reset values:
  - wr_ptr, rd_ptr and count = 0.
  - issue_q_rok = 0, issue_q_wok = 1, issue_q_afull = 0, issue_q_count = 0, issue_q_rdata = 0.
  - Storage contents are not reset.
- Status outputs (combinational from registered state only; no input-to-output combinational path):
  - issue_q_wok = (count != ISSUE_Q_DEPTH).
  - issue_q_rok = (count != 0).
  - issue_q_afull = (count >= AFULL_LEVEL).
  - issue_q_count = count.
- Read data: issue_q_rdata = mem[rd_ptr] when rok=1, otherwise all zeros.
- Accepted transfers:
  - push = wen & wok; pop = ren & rok.
  - ren while rok=0 is ignored; wen while wok=0 is ignored and the data is dropped. The decoder must hold the packet.
- Push: writes mem[wr_ptr] <= wdata, then wr_ptr increments modulo ISSUE_Q_DEPTH (natural wrap at DEPTH_LOG2 bits).
- Pop: rd_ptr increments modulo ISSUE_Q_DEPTH. The next entry appears on rdata in the following cycle.
- Count update: push only +1; pop only -1; both or neither: unchanged.
- Latency: push into an empty queue gives rok=1 and rdata=packet in the cycle after the push edge. There is no same-cycle bypass.
- Full and pop in the same cycle: wok=0, so no push is accepted. Count drops to DEPTH-1 and wok returns to 1 on the next cycle.
- Empty and push in the same cycle: push accepted; the ren in that cycle is ignored.
- Flush (highest priority):
  - On the edge where flush=1, wr_ptr, rd_ptr and count all go to 0.
  - A push or pop in the same cycle is discarded.
  - Next cycle: rok=0, wok=1, count=0.
- Reset mid-operation: immediate return to the reset values regardless of CLK. Buffered packets are lost.

Decomposition:
- Shared backend package holds:
  - ISSUE_Q_WIDTH.
  - Packet field offsets and widths for function, operator, operand, imm, taken, nxt_pc, cur_pc, rs1/rs2/rd ids, so decoder and issuer pack and unpack identically.
- Flat RTL. The storage array may be split into one sub-module, issue_queue_mem: 1 write port, 1 asynchronous read port, no reset.

Test Plan:
1. Reset, then push 0x1, 0x2, 0x3 on consecutive cycles with ren=0 -> rok rises one cycle after the first push, rdata=0x1, count=3, afull=0.
2. Push 8 packets (0x10..0x17) -> count=8, wok=0, afull=1 from count 6 onward; a 9th push of 0x99 is dropped; popping 8 times returns 0x10..0x17 in order, then rok=0 and rdata=0.
3. Full queue with wen=1 and ren=1 in the same cycle -> pop accepted, push rejected, count=7; next cycle wok=1.
4. Count=3 with continuous simultaneous push and pop for 20 cycles -> count stays 3, pointers wrap past 7, output order matches input order.
5. Count=5, flush=1 together with wen=1 and ren=1 -> next cycle count=0, rok=0, wok=1; a following push of 0xAB appears as rdata=0xAB one cycle later.
6. Count=4, deassert RSTN asynchronously mid-cycle -> rok=0, count=0, rdata=0 immediately, before the next CLK edge.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared backend definitions for the decode -> issue buffer.
// Holds the packet width and the field layout of a decoded-instruction packet,
// so the decoder and the issuer pack and unpack packets the same way.
package issue_queue_pkg;

  localparam int ISSUE_Q_WIDTH = 123;

  // Field widths (LSB first in the packet)
  localparam int RD_W    = 5;
  localparam int RS2_W   = 5;
  localparam int RS1_W   = 5;
  localparam int CURPC_W = 32;
  localparam int NXTPC_W = 32;
  localparam int TAKEN_W = 1;
  localparam int IMM_W   = 32;
  localparam int OPND_W  = 4;
  localparam int OPTR_W  = 4;
  localparam int FUNC_W  = 3;

  // Field offsets
  localparam int RD_OFF    = 0;
  localparam int RS2_OFF   = RD_OFF    + RD_W;
  localparam int RS1_OFF   = RS2_OFF   + RS2_W;
  localparam int CURPC_OFF = RS1_OFF   + RS1_W;
  localparam int NXTPC_OFF = CURPC_OFF + CURPC_W;
  localparam int TAKEN_OFF = NXTPC_OFF + NXTPC_W;
  localparam int IMM_OFF   = TAKEN_OFF + TAKEN_W;
  localparam int OPND_OFF  = IMM_OFF   + IMM_W;
  localparam int OPTR_OFF  = OPND_OFF  + OPND_W;
  localparam int FUNC_OFF  = OPTR_OFF  + OPTR_W;

  // The layout must fill the packet exactly
  localparam int PKT_USED = FUNC_OFF + FUNC_W;

  typedef logic [ISSUE_Q_WIDTH-1:0] iq_pkt_t;

endpackage

// File: rtl/issue_queue_if.sv
// issue_queue_if: push/pop/flush handshake between decoder/backend and the
// issue queue.
//   master: decoder + backend side (drives wen/wdata/ren/flush)
//   slave : queue side (drives wok/afull/rok/rdata/count)
interface issue_queue_if #(
  parameter int WIDTH = 123,
  parameter int CW    = 4
) ();
  logic             issue_q_wen;
  logic [WIDTH-1:0] issue_q_wdata;
  logic             issue_q_wok;
  logic             issue_q_afull;
  logic             issue_q_ren;
  logic             issue_q_rok;
  logic [WIDTH-1:0] issue_q_rdata;
  logic [CW-1:0]    issue_q_count;
  logic             flush;

  modport master (
    output issue_q_wen, issue_q_wdata, issue_q_ren, flush,
    input  issue_q_wok, issue_q_afull, issue_q_rok, issue_q_rdata, issue_q_count
  );

  modport slave (
    input  issue_q_wen, issue_q_wdata, issue_q_ren, flush,
    output issue_q_wok, issue_q_afull, issue_q_rok, issue_q_rdata, issue_q_count
  );
endinterface

// File: rtl/issue_queue_mem.sv
// issue_queue_mem: packet storage. One synchronous write port, one
// asynchronous read port, contents not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module issue_queue_mem #(
  parameter int WIDTH = 123,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  import issue_queue_pkg::*;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/issue_queue.sv
// issue_queue: first-word-fall-through FIFO between decode and issue.
//   CLK   : clock
//   RSTN  : asynchronous active-low reset
//   q     : slave side of issue_queue_if
//           push : issue_q_wen / issue_q_wdata / issue_q_wok / issue_q_afull
//           pop  : issue_q_ren / issue_q_rok / issue_q_rdata
//           issue_q_count occupancy, flush discards every entry
// All status outputs derive from registered state only.
module issue_queue #(
  parameter int ISSUE_Q_WIDTH = issue_queue_pkg::ISSUE_Q_WIDTH,
  parameter int ISSUE_Q_DEPTH = 8,
  parameter int AFULL_LEVEL   = 6,
  parameter int DEPTH_LOG2    = $clog2(ISSUE_Q_DEPTH)
) (
  input  logic CLK,
  input  logic RSTN,
  issue_queue_if.slave q
);
  import issue_queue_pkg::*;

  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(ISSUE_Q_DEPTH);
  localparam logic [DEPTH_LOG2:0] AFULL_C = (DEPTH_LOG2+1)'(AFULL_LEVEL);

  logic [DEPTH_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]      count_q,  count_d;
  logic                     wok, rok, push, pop;
  logic [ISSUE_Q_WIDTH-1:0] head;

  assign wok  = (count_q != DEPTH_C);
  assign rok  = (count_q != '0);
  assign push = q.issue_q_wen & wok;
  assign pop  = q.issue_q_ren & rok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally at DEPTH_LOG2 bits (depth is a power of two)
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A flushed push must not corrupt storage that a later push relies on; it is
  // harmless either way because wr_ptr returns to 0, but gate it for clarity.
  issue_queue_mem #(
    .WIDTH (ISSUE_Q_WIDTH),
    .DEPTH (ISSUE_Q_DEPTH),
    .AW    (DEPTH_LOG2)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (push & ~q.flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (q.issue_q_wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign q.issue_q_wok   = wok;
  assign q.issue_q_rok   = rok;
  assign q.issue_q_afull = (count_q >= AFULL_C);
  assign q.issue_q_count = count_q;
  // Empty queue presents zeros rather than stale storage
  assign q.issue_q_rdata = rok ? head : '0;
endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int W  = ISSUE_Q_WIDTH;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int CW = 4;

  logic CLK;
  logic RSTN;
  issue_queue_if #(.WIDTH(W), .CW(CW)) qif ();

  issue_queue #(
    .ISSUE_Q_WIDTH (W),
    .ISSUE_Q_DEPTH (D),
    .AFULL_LEVEL   (AF),
    .DEPTH_LOG2    (3)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .q    (qif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] sb[$];
  int model_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check status and head against the model, then clock one cycle.
  task automatic cyc(input logic wen, input logic [W-1:0] wd, input logic ren, input logic fl);
    logic do_push, do_pop;
    qif.issue_q_wen   = wen;
    qif.issue_q_wdata = wd;
    qif.issue_q_ren   = ren;
    qif.flush         = fl;
    chk("count", 128'(qif.issue_q_count), 128'(model_cnt));
    chk("rok",   128'(qif.issue_q_rok),   128'(model_cnt != 0));
    chk("wok",   128'(qif.issue_q_wok),   128'(model_cnt != D));
    chk("afull", 128'(qif.issue_q_afull), 128'(model_cnt >= AF));
    if (model_cnt != 0) chk("rdata", 128'(qif.issue_q_rdata), 128'(sb[0]));
    else                chk("rdata_empty", 128'(qif.issue_q_rdata), 128'(0));
    do_push = wen && (model_cnt != D);
    do_pop  = ren && (model_cnt != 0);
    if (fl) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      if (do_pop) begin
        void'(sb.pop_front());
        model_cnt--;
      end
      if (do_push) begin
        sb.push_back(wd);
        model_cnt++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (model_cnt != 0) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    RSTN = 1'b0;
    qif.issue_q_wen   = 1'b0;
    qif.issue_q_wdata = '0;
    qif.issue_q_ren   = 1'b0;
    qif.flush         = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rok",   128'(qif.issue_q_rok),   128'(0));
    chk("rst_wok",   128'(qif.issue_q_wok),   128'(1));
    chk("rst_afull", 128'(qif.issue_q_afull), 128'(0));
    chk("rst_count", 128'(qif.issue_q_count), 128'(0));
    chk("rst_rdata", 128'(qif.issue_q_rdata), 128'(0));
    RSTN = 1'b1;
    @(posedge CLK);
    #1;

    // 1: three pushes, head visible one cycle after first push
    cyc(1'b1, W'(1), 1'b0, 1'b0);
    chk("t1_rok_lat",   128'(qif.issue_q_rok),   128'(1));
    chk("t1_rdata_lat", 128'(qif.issue_q_rdata), 128'(1));
    cyc(1'b1, W'(2), 1'b0, 1'b0);
    cyc(1'b1, W'(3), 1'b0, 1'b0);
    chk("t1_count", 128'(qif.issue_q_count), 128'(3));
    chk("t1_afull", 128'(qif.issue_q_afull), 128'(0));
    idle();
    drain();

    // 2: fill to full, dropped 9th push, ordered drain
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(32'h10 + i), 1'b0, 1'b0);
    chk("t2_full_count", 128'(qif.issue_q_count), 128'(8));
    chk("t2_full_wok",   128'(qif.issue_q_wok),   128'(0));
    cyc(1'b1, W'(32'h99), 1'b0, 1'b0);
    chk("t2_drop_count", 128'(qif.issue_q_count), 128'(8));
    for (int i = 0; i < 8; i++) begin
      chk("t2_order", 128'(qif.issue_q_rdata), 128'(32'h10 + i));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("t2_empty_rok",   128'(qif.issue_q_rok),   128'(0));
    chk("t2_empty_rdata", 128'(qif.issue_q_rdata), 128'(0));
    cyc(1'b0, '0, 1'b1, 1'b0); // pop while empty ignored

    // 3: full with simultaneous push and pop
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(32'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, W'(32'h55), 1'b1, 1'b0);
    chk("t3_count", 128'(qif.issue_q_count), 128'(7));
    chk("t3_wok",   128'(qif.issue_q_wok),   128'(1));
    idle();
    drain();

    // 4: steady-state push+pop with pointer wrap
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0);
    chk("t4_count", 128'(qif.issue_q_count), 128'(3));
    drain();

    // empty + push + ren in the same cycle: push taken, ren ignored
    cyc(1'b1, W'(32'h77), 1'b1, 1'b0);
    chk("empty_pushpop_count", 128'(qif.issue_q_count), 128'(1));
    drain();

    // 5: flush beats simultaneous push and pop
    for (int i = 0; i < 5; i++) cyc(1'b1, W'(32'h200 + i), 1'b0, 1'b0);
    cyc(1'b1, W'(32'hEE), 1'b1, 1'b1);
    chk("t5_count", 128'(qif.issue_q_count), 128'(0));
    chk("t5_rok",   128'(qif.issue_q_rok),   128'(0));
    chk("t5_wok",   128'(qif.issue_q_wok),   128'(1));
    cyc(1'b1, W'(32'hAB), 1'b0, 1'b0);
    chk("t5_rdata", 128'(qif.issue_q_rdata), 128'(32'hAB));
    idle();
    drain();

    // 6: asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(32'h300 + i), 1'b0, 1'b0);
    chk("t6_pre_count", 128'(qif.issue_q_count), 128'(4));
    qif.issue_q_wen = 1'b0;
    #2;
    RSTN = 1'b0;
    #1;
    chk("t6_rok",   128'(qif.issue_q_rok),   128'(0));
    chk("t6_count", 128'(qif.issue_q_count), 128'(0));
    chk("t6_rdata", 128'(qif.issue_q_rdata), 128'(0));
    sb.delete();
    model_cnt = 0;
    @(posedge CLK);
    #3;
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    cyc(1'b1, W'(32'h3C), 1'b0, 1'b0);
    idle();
    drain();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
